encoder: RTL and testbench
==========================

ENCODER -- requirements
Module: encoder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: qualifies x for the current cycle.
REQ-005 The block SHALL have port x, input, 4 bits: request vector; x[3] is highest priority, x[0] lowest.
REQ-006 The block SHALL have port y, output, 2 bits: registered index of the highest-priority set bit of x.
REQ-007 The block SHALL have port y_valid, output, 1 bit: y, zero and multi hold a fresh result this cycle.
REQ-008 The block SHALL have port zero, output, 1 bit: the captured x was 4'b0000.
REQ-009 The block SHALL have port multi, output, 1 bit: the captured x had two or more bits set.

Function
REQ-010 The encoding SHALL follow this priority table:
- x[3]=1 -> y=3
- x[3:2]=01 -> y=2
- x[3:1]=001 -> y=1
- otherwise -> y=0
REQ-011 Lower-priority bits SHALL have no effect on y once a higher bit is set.
REQ-012 When x=4'b0000, the block SHALL output y=0 and zero=1; for any nonzero x, zero=0.
- zero SHALL distinguish x=0000 from x=0001; both give y=0.
REQ-013 The block SHALL set multi=1 exactly when popcount(x)>=2.
REQ-014 Latency SHALL be exactly 1 cycle: when in_valid=1 at rising edge N, y, zero and multi reflect that x, and y_valid=1, from edge N until edge N+1.
REQ-015 When in_valid=0 at a rising edge, y_valid SHALL go to 0 at that edge.
- y, zero and multi SHALL hold their previous values on that edge.
REQ-016 Back-to-back valid inputs SHALL each produce one result per cycle, with no bubbles and no backpressure.
REQ-017 The outputs SHALL depend only on the captured x and SHALL NOT depend on x values between rising edges.
REQ-018 The outputs SHALL NOT be driven directly by combinational paths from the inputs; all outputs are registered.

Reset
REQ-019 While rst=1, the block SHALL force y=0, y_valid=0, zero=0 and multi=0 immediately, independent of clk.
REQ-020 On rst deassertion, the first result SHALL appear one cycle after the first rising edge with in_valid=1.
REQ-021 If rst asserts while a result is pending, the pending result SHALL be discarded and no y_valid pulse emitted for it.
REQ-022 X or Z on x while in_valid=0 SHALL NOT propagate to any output.

Verification
REQ-023 The bench SHALL cover each of the following directed scenarios, checking outputs 1 cycle after stimulus:
- x=1000, in_valid=1 -> y=3, y_valid=1, zero=0, multi=0.
- x=0110, in_valid=1 -> y=2, multi=1, zero=0.
- x=0011, in_valid=1, then x=0001 next cycle -> y=1, multi=1, then y=0, zero=0, multi=0, y_valid=1 both cycles.
- x=0000, in_valid=1 -> y=0, zero=1, multi=0, y_valid=1.
- x=1111, in_valid=1 then in_valid=0 with x=0001 -> y=3, y_valid=1, then y_valid=0, y still 3.
- rst pulsed mid-cycle after valid x=0100 -> all outputs 0 without waiting for a clock edge.
REQ-024 The bench SHALL exhaustively sweep all 16 x values with in_valid=1 against the REQ-010/012/013 reference model.

Source files
------------

// File: rtl/encoder.sv
// encoder: registered 4-to-2 priority encoder with zero / multi-hot flags.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset; clears all outputs at once
//   in_valid in   qualifies x on the current rising edge
//   x[3:0]   in   request vector, x[3] highest priority
//   y[1:0]   out  index of highest-priority set bit of the captured x
//   y_valid  out  y/zero/multi hold a fresh result this cycle
//   zero     out  captured x was all zeros
//   multi    out  captured x had two or more bits set
//
// One-cycle latency, one result per cycle, no backpressure. On an edge with
// in_valid=0 only y_valid drops; y/zero/multi keep the last captured result.
module encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] x,
    output logic [1:0] y,
    output logic       y_valid,
    output logic       zero,
    output logic       multi
);

    logic [1:0] enc_y;
    logic       enc_zero;
    logic       enc_multi;

    // Priority decode: the first set bit from the top wins, lower bits ignored.
    always_comb begin
        enc_y = 2'd0;
        if (x[3])      enc_y = 2'd3;
        else if (x[2]) enc_y = 2'd2;
        else if (x[1]) enc_y = 2'd1;
        else           enc_y = 2'd0;
    end

    assign enc_zero = ~|x;

    // Two or more bits set <=> at least one pair of bits is set together.
    assign enc_multi = (x[3] & x[2]) | (x[3] & x[1]) | (x[3] & x[0]) |
                       (x[2] & x[1]) | (x[2] & x[0]) | (x[1] & x[0]);

    // Result registers only load when in_valid is high, so an unknown x on
    // an idle cycle never reaches the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= 2'd0;
            y_valid <= 1'b0;
            zero    <= 1'b0;
            multi   <= 1'b0;
        end else begin
            y_valid <= in_valid;
            if (in_valid) begin
                y     <= enc_y;
                zero  <= enc_zero;
                multi <= enc_multi;
            end
        end
    end

endmodule

// File: tb/tb_encoder.sv
// tb_encoder: self-checking bench for encoder. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge. Expected
// results are pushed to a scoreboard queue when a valid input is driven and
// popped when the DUT presents y_valid.
module tb_encoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] x;
    logic [1:0] y;
    logic       y_valid;
    logic       zero;
    logic       multi;

    int checks   = 0;
    int failures = 0;

    logic [3:0] sb[$];      // expected {y, zero, multi}
    logic [3:0] last_exp;   // most recent result the DUT should be holding
    logic [3:0] got;
    logic [3:0] exp;

    encoder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .x        (x),
        .y        (y),
        .y_valid  (y_valid),
        .zero     (zero),
        .multi    (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: scan for the highest set bit and count ones independently.
    function automatic logic [3:0] model(input logic [3:0] v);
        logic [1:0] idx;
        int         ones;
        idx  = 2'd0;
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx  = 2'(i);
                ones = ones + 1;
            end
        end
        return {idx, (ones == 0), (ones >= 2)};
    endfunction

    // Drive one cycle of stimulus and advance to just after the capturing edge.
    task automatic step(input logic v, input logic [3:0] xv);
        @(negedge clk);
        in_valid = v;
        x        = xv;
        if (v) sb.push_back(model(xv));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        x        = 4'b0000;
        #3;
        checks++;
        if ({y, y_valid, zero, multi} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00000", {y, y_valid, zero, multi});
        end
        #20;
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 4'b1010);
        checks++;
        if (y_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle y_valid got=%b want=0", y_valid);
        end
    endtask

    task automatic test_directed;
        logic [3:0] pat [5];
        pat = '{4'b1000, 4'b0110, 4'b0011, 4'b0001, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, pat[i]);
            checks++;
            if (y_valid !== 1'b1 || sb.size() == 0) begin
                failures++;
                $display("FAIL directed_valid x=%b y_valid got=%b want=1", pat[i], y_valid);
                sb.delete();
            end else begin
                exp = sb.pop_front();
                got = {y, zero, multi};
                last_exp = exp;
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL directed x=%b {y,zero,multi} got=%b want=%b", pat[i], got, exp);
                end
            end
        end
    endtask

    task automatic test_hold;
        step(1'b1, 4'b1111);
        exp = sb.pop_front();
        last_exp = exp;
        checks++;
        if (y_valid !== 1'b1 || {y, zero, multi} !== 4'b1101) begin
            failures++;
            $display("FAIL hold_capture got=%b%b want=1 1101", y_valid, {y, zero, multi});
        end
        step(1'b0, 4'b0001);
        checks++;
        if (y_valid !== 1'b0 || {y, zero, multi} !== last_exp) begin
            failures++;
            $display("FAIL hold_idle y_valid=%b {y,zero,multi} got=%b want=0 %b",
                     y_valid, {y, zero, multi}, last_exp);
        end
        // Unknown x on an idle cycle must not leak into the outputs.
        step(1'b0, 4'bxz1x);
        checks++;
        if (y_valid !== 1'b0 || {y, zero, multi} !== last_exp) begin
            failures++;
            $display("FAIL idle_x_block y_valid=%b {y,zero,multi} got=%b want=0 %b",
                     y_valid, {y, zero, multi}, last_exp);
        end
    endtask

    task automatic test_sweep;
        for (int v = 0; v < 16; v++) begin
            step(1'b1, 4'(v));
            checks++;
            if (y_valid !== 1'b1 || sb.size() == 0) begin
                failures++;
                $display("FAIL sweep_valid x=%b y_valid got=%b want=1", 4'(v), y_valid);
                sb.delete();
            end else begin
                exp = sb.pop_front();
                got = {y, zero, multi};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL sweep x=%b {y,zero,multi} got=%b want=%b", 4'(v), got, exp);
                end
            end
        end
        step(1'b0, 4'b0000);
        checks++;
        if (y_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL sweep_drain y_valid=%b pending=%0d want=0 0", y_valid, sb.size());
        end
    endtask

    task automatic test_async_reset;
        step(1'b1, 4'b0100);
        exp = sb.pop_front();
        checks++;
        if (y_valid !== 1'b1 || {y, zero, multi} !== exp) begin
            failures++;
            $display("FAIL arst_capture got=%b%b want=1 %b", y_valid, {y, zero, multi}, exp);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({y, y_valid, zero, multi} !== 5'b0) begin
            failures++;
            $display("FAIL arst_midcycle got=%b want=00000", {y, y_valid, zero, multi});
        end
        @(negedge clk);
        rst = 1'b0;
        // A valid input is presented, then reset hits before its capture edge.
        @(negedge clk);
        in_valid = 1'b1;
        x        = 4'b1001;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (y_valid !== 1'b0 || {y, zero, multi} !== 4'b0) begin
            failures++;
            $display("FAIL arst_discard y_valid=%b {y,zero,multi} got=%b want=0 0000",
                     y_valid, {y, zero, multi});
        end
        // First result after reset release arrives one edge after valid.
        step(1'b1, 4'b0010);
        checks++;
        if (y_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL arst_first y_valid got=%b want=1", y_valid);
            sb.delete();
        end else begin
            exp = sb.pop_front();
            checks++;
            if ({y, zero, multi} !== exp) begin
                failures++;
                $display("FAIL arst_first {y,zero,multi} got=%b want=%b", {y, zero, multi}, exp);
            end
        end
    endtask

    initial begin
        last_exp = 4'b0;
        test_reset();
        test_directed();
        test_hold();
        test_sweep();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
